// File: rtl/ram_bist_pkg.sv
// Shared state encoding and March C- element table for the RAM BIST controller.
package ram_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One March element: address direction, read-expect and write patterns, op mix
    typedef struct packed {
        logic down;
        logic rd_pat;
        logic wr_pat;
        logic has_rd;
        logic has_wr;
    } elem_t;

    localparam logic PAT_D0 = 1'b0;
    localparam logic PAT_D1 = 1'b1;

    localparam elem_t EL_M0   = '{down: 1'b0, rd_pat: PAT_D0, wr_pat: PAT_D0, has_rd: 1'b0, has_wr: 1'b1};
    localparam elem_t EL_M1   = '{down: 1'b0, rd_pat: PAT_D0, wr_pat: PAT_D1, has_rd: 1'b1, has_wr: 1'b1};
    localparam elem_t EL_M2   = '{down: 1'b0, rd_pat: PAT_D1, wr_pat: PAT_D0, has_rd: 1'b1, has_wr: 1'b1};
    localparam elem_t EL_M3   = '{down: 1'b1, rd_pat: PAT_D0, wr_pat: PAT_D1, has_rd: 1'b1, has_wr: 1'b1};
    localparam elem_t EL_M4   = '{down: 1'b1, rd_pat: PAT_D1, wr_pat: PAT_D0, has_rd: 1'b1, has_wr: 1'b1};
    localparam elem_t EL_M5   = '{down: 1'b1, rd_pat: PAT_D0, wr_pat: PAT_D0, has_rd: 1'b1, has_wr: 1'b0};
    localparam elem_t EL_NONE = '0;

    function automatic elem_t elem_of(input state_t s);
        case (s)
            ST_M0:   return EL_M0;
            ST_M1:   return EL_M1;
            ST_M2:   return EL_M2;
            ST_M3:   return EL_M3;
            ST_M4:   return EL_M4;
            ST_M5:   return EL_M5;
            default: return EL_NONE;
        endcase
    endfunction

    function automatic logic is_march(input state_t s);
        return s inside {ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5};
    endfunction

    function automatic state_t next_elem(input state_t s);
        case (s)
            ST_M0:   return ST_M1;
            ST_M1:   return ST_M2;
            ST_M2:   return ST_M3;
            ST_M3:   return ST_M4;
            default: return ST_M5;
        endcase
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data compare for the BIST: aligns expected data/address with RAM read latency
// and captures the first failing address and data.
module ram_bist_cmp #(
    parameter int AW     = 4,
    parameter int DW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          rd_vld,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_exp,
    input  logic [DW-1:0] ram_rdata,
    output logic          mismatch,
    output logic          fail_flag,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_rdata
);

    logic          cmp_vld;
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] cmp_exp;

    generate
        if (RD_LAT == 1) begin : g_lat1
            logic          vld_p1;
            logic [AW-1:0] addr_p1;
            logic [DW-1:0] exp_p1;

            // p0 -> p1: read issued, data returns next cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= rd_vld;
                end
                addr_p1 <= rd_addr;
                exp_p1  <= rd_exp;
            end

            assign cmp_vld  = vld_p1;
            assign cmp_addr = addr_p1;
            assign cmp_exp  = exp_p1;
        end else begin : g_lat0
            assign cmp_vld  = rd_vld;
            assign cmp_addr = rd_addr;
            assign cmp_exp  = rd_exp;
        end
    endgenerate

    assign mismatch = cmp_vld && (ram_rdata != cmp_exp);

    // Only the first mismatch of a run is kept
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fail_flag  <= 1'b0;
            fail_addr  <= '0;
            fail_rdata <= '0;
        end else if (mismatch && !fail_flag) begin
            fail_flag  <= 1'b1;
            fail_addr  <= cmp_addr;
            fail_rdata <= ram_rdata;
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller sitting between functional requesters and a single-port RAM.
// Optional build macro BIST_STOP_ON_FAIL_EN aborts the test at the first mismatch.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int AW     = 4,
    parameter int DW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_rdata,
    input  logic          func_we,
    input  logic [AW-1:0] func_addr,
    input  logic [DW-1:0] func_wdata,
    output logic [DW-1:0] func_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

`ifdef BIST_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    function automatic logic [DW-1:0] fill(input logic b);
        return {DW{b}};
    endfunction

    state_t        state, nxt_state;
    logic [AW-1:0] addr, nxt_addr;
    logic          phase, nxt_phase;
    logic          pass_q;
    logic          start_acc;
    elem_t         el, nel;
    logic          march;
    logic          rd_op, wr_op, last_op, last_addr;
    logic          mismatch, fail_flag;

    // phase 0 is the read of a read-then-write element, phase 1 its write
    assign el        = elem_of(state);
    assign march     = is_march(state);
    assign rd_op     = march && el.has_rd && !phase;
    assign wr_op     = march && el.has_wr && (phase || !el.has_rd);
    assign last_op   = !(el.has_rd && el.has_wr) || phase;
    assign last_addr = el.down ? (addr == '0) : (addr == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr   <= '0;
            phase  <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            state <= nxt_state;
            addr  <= nxt_addr;
            phase <= nxt_phase;
            if (start_acc) begin
                pass_q <= 1'b0;
            end else if (nxt_state == ST_DONE && state != ST_DONE) begin
                pass_q <= !(fail_flag || mismatch);
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_addr  = addr;
        nxt_phase = phase;
        start_acc = 1'b0;
        nel       = elem_of(next_elem(state));
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    nxt_state = ST_M0;
                    nxt_addr  = EL_M0.down ? '1 : '0;
                    nxt_phase = 1'b0;
                end
            end
            ST_DRAIN: nxt_state = ST_DONE;
            default: begin
                if (march) begin
                    if (!last_op) begin
                        nxt_phase = 1'b1;
                    end else begin
                        nxt_phase = 1'b0;
                        if (!last_addr) begin
                            nxt_addr = el.down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
                        end else if (state == ST_M5) begin
                            nxt_state = (RD_LAT == 1) ? ST_DRAIN : ST_DONE;
                        end else begin
                            // element boundary: restart the counter for the next direction
                            nxt_state = next_elem(state);
                            nxt_addr  = nel.down ? '1 : '0;
                        end
                    end
                end
            end
        endcase
        if (STOP_ON_FAIL && mismatch && (march || state == ST_DRAIN)) begin
            nxt_state = ST_DONE;
        end
    end

    always_comb begin
        ram_we    = func_we;
        ram_addr  = func_addr;
        ram_wdata = func_wdata;
        if (state != ST_IDLE && state != ST_DONE) begin
            ram_we    = wr_op;
            ram_addr  = addr;
            ram_wdata = fill(el.wr_pat);
        end
    end

    assign func_rdata = ram_rdata;
    assign busy       = march || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign pass       = pass_q;

    ram_bist_cmp #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .rd_vld     (rd_op),
        .rd_addr    (addr),
        .rd_exp     (fill(el.rd_pat)),
        .ram_rdata  (ram_rdata),
        .mismatch   (mismatch),
        .fail_flag  (fail_flag),
        .fail_addr  (fail_addr),
        .fail_rdata (fail_rdata)
    );

endmodule
